// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared types for the 5-stage MIPS datapath and its hazard
//               control: register index, data word, next-PC select and the
//               hazard controller state.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

  typedef logic [4:0]  regbits_t;
  typedef logic [31:0] word_t;

  // Next-PC source: sequential, jump target from ID, branch target from MEM
  typedef enum logic [1:0] {
    PC_NEXT   = 2'd0,
    PC_JUMP   = 2'd1,
    PC_BRANCH = 2'd2
  } pcsel_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } hzstate_t;

  // $zero never carries a real dependency
  localparam regbits_t c_REG_ZERO = 5'd0;

endpackage
`default_nettype wire

// File: rtl/hazard_perf_counter.sv
`default_nettype none
// ============================================================================
// Module      : hazard_perf_counter
// Description : Saturating event counter with synchronous clear. Sticks at
//               all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Step on each event until the counter reaches all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != c_MAX)) begin
      cnt_d = cnt_q + c_ONE;
    end
  end

  // Count register; clear acts as the synchronous reset
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Pipeline-register enable/flush and PC control for the 5-stage
//               MIPS datapath. Handles load-use stalls, dcache waits, branch
//               and jump flushes, icache misses and a sticky halt, and counts
//               stall and flush cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [4:0]       idrsel1,
  input  logic [4:0]       idrsel2,
  input  logic             id_uses_rt,
  input  logic             idjmp,
  input  logic             exMemRead,
  input  logic [4:0]       exwsel,
  input  logic             memcuDRE,
  input  logic             memcuDWE,
  input  logic             mem_brtaken,
  input  logic             memcuHALT,
  output logic             pcW,
  output logic [1:0]       pc_sel,
  output logic             ifW,
  output logic             ifRST,
  output logic             idW,
  output logic             idRST,
  output logic             exW,
  output logic             exRST,
  output logic             memW,
  output logic             memRST,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hzstate_t state_q;
  hzstate_t state_d;

  logic   dwait_req;
  logic   load_use;
  logic   pc_we;
  pcsel_t pc_src;
  logic   if_we, id_we, ex_we, mem_we;
  logic   if_fl, id_fl, ex_fl, mem_fl;
  logic   halt_w;
  logic   stall_inc;
  logic   flush_inc;

  // A memory op in MEM that the dcache has not finished freezes the whole pipe
  assign dwait_req = (memcuDRE | memcuDWE) & ~dhit;

  // Load in EX whose destination feeds the ID instruction; $zero is ignored
  assign load_use = exMemRead & (exwsel != c_REG_ZERO) &
                    ((exwsel == idrsel1) | (id_uses_rt & (exwsel == idrsel2)));

  // State register; reset aborts any wait or halt
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus prioritized pipeline control decode
  always_comb begin
    state_d = state_q;
    pc_we   = 1'b1;
    pc_src  = PC_NEXT;
    if_we   = 1'b1;
    id_we   = 1'b1;
    ex_we   = 1'b1;
    mem_we  = 1'b1;
    if_fl   = 1'b0;
    id_fl   = 1'b0;
    ex_fl   = 1'b0;
    mem_fl  = 1'b0;
    halt_w  = 1'b0;

    if (memcuHALT) begin
      state_d = HALTED;
    end else begin
      case (state_q)
        RUN:     if (dwait_req) state_d = DWAIT;
        DWAIT:   if (dhit) state_d = RUN;
        HALTED:  state_d = HALTED;
        default: state_d = RUN;
      endcase
    end

    if (RST) begin
      pc_we  = 1'b0;
      if_fl  = 1'b1;
      id_fl  = 1'b1;
      ex_fl  = 1'b1;
      mem_fl = 1'b1;
    end else if (state_q == HALTED) begin
      pc_we  = 1'b0;
      if_we  = 1'b0;
      id_we  = 1'b0;
      ex_we  = 1'b0;
      mem_we = 1'b0;
      halt_w = 1'b1;
    end else if (dwait_req) begin
      // MEM/WB is written on the dhit cycle, so every stage holds here
      pc_we  = 1'b0;
      if_we  = 1'b0;
      id_we  = 1'b0;
      ex_we  = 1'b0;
      mem_we = 1'b0;
    end else if (mem_brtaken) begin
      // Kill the three younger instructions fetched down the wrong path
      pc_src = PC_BRANCH;
      if_fl  = 1'b1;
      id_fl  = 1'b1;
      ex_fl  = 1'b1;
    end else if (load_use) begin
      // One bubble; next cycle the load sits in MEM and forwarding covers it
      pc_we  = 1'b0;
      if_we  = 1'b0;
      id_fl  = 1'b1;
    end else if (idjmp) begin
      pc_src = PC_JUMP;
      if_fl  = 1'b1;
    end else if (!ihit) begin
      pc_we  = 1'b0;
      if_fl  = 1'b1;
    end
  end

  // A flushed stage is never also written
  assign ifW    = if_we  & ~if_fl;
  assign idW    = id_we  & ~id_fl;
  assign exW    = ex_we  & ~ex_fl;
  assign memW   = mem_we & ~mem_fl;
  assign ifRST  = if_fl;
  assign idRST  = id_fl;
  assign exRST  = ex_fl;
  assign memRST = mem_fl;
  assign pcW    = pc_we;
  assign pc_sel = pc_src;
  assign halt   = halt_w;

  // Performance events exclude reset cycles and freeze once halted
  assign stall_inc = ~RST & (state_q != HALTED) & ~pc_we;
  assign flush_inc = ~RST & (state_q != HALTED) & (if_fl | id_fl | ex_fl | mem_fl);

  hazard_perf_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk_i (CLK),
    .clr_i (RST),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt)
  );

  hazard_perf_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk_i (CLK),
    .clr_i (RST),
    .inc_i (flush_inc),
    .cnt_o (flush_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Self-checking bench for pipeline_hazard_ctrl. Directed
//               scenarios plus randomized traffic against a behavioural
//               model built from per-stage flush/hold masks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 4;

  logic             CLK = 1'b0;
  logic             RST;
  logic             ihit, dhit, id_uses_rt, idjmp, exMemRead;
  logic [4:0]       idrsel1, idrsel2, exwsel;
  logic             memcuDRE, memcuDWE, mem_brtaken, memcuHALT;
  logic             pcW, ifW, ifRST, idW, idRST, exW, exRST, memW, memRST, halt;
  logic [1:0]       pc_sel;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Model state
  logic             m_halted = 1'b0;
  logic [CNT_W-1:0] m_stall  = '0;
  logic [CNT_W-1:0] m_flush  = '0;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .idrsel1(idrsel1), .idrsel2(idrsel2), .id_uses_rt(id_uses_rt),
    .idjmp(idjmp), .exMemRead(exMemRead), .exwsel(exwsel),
    .memcuDRE(memcuDRE), .memcuDWE(memcuDWE), .mem_brtaken(mem_brtaken),
    .memcuHALT(memcuHALT), .pcW(pcW), .pc_sel(pc_sel),
    .ifW(ifW), .ifRST(ifRST), .idW(idW), .idRST(idRST),
    .exW(exW), .exRST(exRST), .memW(memW), .memRST(memRST),
    .halt(halt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  // Expected {pcW, pc_sel, ifW, ifRST, idW, idRST, exW, exRST, memW, memRST, halt}.
  // Each situation is described by which stages are flushed and which hold;
  // a stage writes only when neither applies. Stage order: [3]=IF ... [0]=MEM.
  function automatic logic [11:0] model_vec();
    logic [3:0] fl, hd;
    logic       pw, h, dw, lu;
    logic [1:0] ps;
    dw = (memcuDRE || memcuDWE) && !dhit;
    lu = exMemRead && (exwsel != 5'd0) &&
         ((exwsel == idrsel1) || (id_uses_rt && (exwsel == idrsel2)));
    fl = 4'b0000; hd = 4'b0000; pw = 1'b1; ps = 2'd0; h = 1'b0;
    if (RST)              begin fl = 4'b1111; pw = 1'b0; end
    else if (m_halted)    begin hd = 4'b1111; pw = 1'b0; h = 1'b1; end
    else if (dw)          begin hd = 4'b1111; pw = 1'b0; end
    else if (mem_brtaken) begin fl = 4'b1110; ps = 2'd2; end
    else if (lu)          begin fl = 4'b0100; hd = 4'b1000; pw = 1'b0; end
    else if (idjmp)       begin fl = 4'b1000; ps = 2'd1; end
    else if (!ihit)       begin fl = 4'b1000; pw = 1'b0; end
    return {pw, ps,
            !(fl[3] || hd[3]), fl[3], !(fl[2] || hd[2]), fl[2],
            !(fl[1] || hd[1]), fl[1], !(fl[0] || hd[0]), fl[0], h};
  endfunction

  // Advance one clock, updating the model from what held before the edge
  task automatic tick();
    logic [11:0] e;
    e = model_vec();
    @(posedge CLK);
    if (RST) begin
      m_halted = 1'b0;
      m_stall  = '0;
      m_flush  = '0;
    end else begin
      if (!m_halted) begin
        if (!e[11] && (m_stall != {CNT_W{1'b1}})) m_stall = m_stall + 1'b1;
        if ((e[7] || e[5] || e[3] || e[1]) && (m_flush != {CNT_W{1'b1}}))
          m_flush = m_flush + 1'b1;
      end
      if (memcuHALT) m_halted = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    RST = 1'b0; ihit = 1'b1; dhit = 1'b0; idrsel1 = 5'd0; idrsel2 = 5'd0;
    id_uses_rt = 1'b0; idjmp = 1'b0; exMemRead = 1'b0; exwsel = 5'd0;
    memcuDRE = 1'b0; memcuDWE = 1'b0; mem_brtaken = 1'b0; memcuHALT = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    RST = 1'b1; mem_brtaken = 1'b1; idjmp = 1'b1;
    tick();
    @(negedge CLK);
    n_vec++;
    if ({ifW, idW, exW, memW, pcW} !== 5'b00000) begin
      n_err++; $display("FAIL reset_we: got %b want 00000", {ifW, idW, exW, memW, pcW});
    end
    n_vec++;
    if ({ifRST, idRST, exRST, memRST, halt, pc_sel} !== 7'b1111000) begin
      n_err++; $display("FAIL reset_fl: got %b want 1111000",
                        {ifRST, idRST, exRST, memRST, halt, pc_sel});
    end
    n_vec++;
    if ({stall_cnt, flush_cnt} !== 8'h00) begin
      n_err++; $display("FAIL reset_cnt: stall %0d flush %0d want 0 0", stall_cnt, flush_cnt);
    end
    tick();
    idle();
    @(negedge CLK);
    n_vec++;
    if ({pcW, ifW, idW, exW, memW, ifRST, idRST, exRST, memRST, pc_sel} !== 11'b11111000000) begin
      n_err++; $display("FAIL run_default: got %b want 11111000000",
                        {pcW, ifW, idW, exW, memW, ifRST, idRST, exRST, memRST, pc_sel});
    end
    tick();
  endtask

  task automatic test_load_use();
    idle();
    exMemRead = 1'b1; exwsel = 5'd3; idrsel1 = 5'd3;
    @(negedge CLK);
    n_vec++;
    if ({pcW, ifW, idRST, idW, exW, memW} !== 6'b001011) begin
      n_err++; $display("FAIL load_use: got %b want 001011", {pcW, ifW, idRST, idW, exW, memW});
    end
    tick();
    idle();
    @(negedge CLK);
    n_vec++;
    if (stall_cnt !== 4'd1 || stall_cnt !== m_stall) begin
      n_err++; $display("FAIL load_use_cnt: stall %0d want 1", stall_cnt);
    end
    n_vec++;
    if (pcW !== 1'b1 || ifW !== 1'b1) begin
      n_err++; $display("FAIL load_use_release: pcW %b ifW %b want 1 1", pcW, ifW);
    end
    tick();
  endtask

  task automatic test_no_stall();
    idle();
    exMemRead = 1'b1; exwsel = 5'd0; idrsel1 = 5'd0;
    @(negedge CLK);
    n_vec++;
    if ({pcW, ifW, idW, exW, memW, idRST} !== 6'b111110) begin
      n_err++; $display("FAIL lu_zero_reg: got %b want 111110", {pcW, ifW, idW, exW, memW, idRST});
    end
    tick();
    exwsel = 5'd5; idrsel1 = 5'd7; idrsel2 = 5'd5; id_uses_rt = 1'b0;
    @(negedge CLK);
    n_vec++;
    if ({pcW, ifW, idW, idRST} !== 4'b1110) begin
      n_err++; $display("FAIL lu_rt_unused: got %b want 1110", {pcW, ifW, idW, idRST});
    end
    tick();
    id_uses_rt = 1'b1;
    @(negedge CLK);
    n_vec++;
    if ({pcW, ifW, idW, idRST} !== 4'b0001) begin
      n_err++; $display("FAIL lu_rt_used: got %b want 0001", {pcW, ifW, idW, idRST});
    end
    tick();
  endtask

  task automatic test_dcache_miss();
    idle();
    memcuDRE = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      n_vec++;
      if ({pcW, ifW, idW, exW, memW, ifRST, idRST, exRST, memRST} !== 9'b0) begin
        n_err++; $display("FAIL dwait_hold[%0d]: got %b want 000000000", i,
                          {pcW, ifW, idW, exW, memW, ifRST, idRST, exRST, memRST});
      end
      tick();
    end
    dhit = 1'b1;
    @(negedge CLK);
    n_vec++;
    if ({memW, pcW, ifW} !== 3'b111) begin
      n_err++; $display("FAIL dwait_done: memW %b pcW %b ifW %b want 1 1 1", memW, pcW, ifW);
    end
    tick();
    idle();
    @(negedge CLK);
    n_vec++;
    if (stall_cnt !== m_stall) begin
      n_err++; $display("FAIL dwait_cnt: stall %0d want %0d", stall_cnt, m_stall);
    end
    tick();
  endtask

  task automatic test_branch_flush();
    logic [CNT_W-1:0] f0;
    idle();
    @(negedge CLK);
    f0 = flush_cnt;
    mem_brtaken = 1'b1; idjmp = 1'b1; ihit = 1'b0;
    #1;
    n_vec++;
    if ({pcW, pc_sel, ifRST, idRST, exRST, memRST, memW} !== 8'b11011101) begin
      n_err++; $display("FAIL branch_flush: got %b want 11011101",
                        {pcW, pc_sel, ifRST, idRST, exRST, memRST, memW});
    end
    tick();
    idle();
    @(negedge CLK);
    n_vec++;
    if (flush_cnt !== f0 + 4'd1 || flush_cnt !== m_flush) begin
      n_err++; $display("FAIL branch_cnt: flush %0d want %0d", flush_cnt, m_flush);
    end
    tick();
  endtask

  task automatic test_halt();
    idle();
    memcuDRE = 1'b1; memcuHALT = 1'b1;
    @(negedge CLK);
    n_vec++;
    if ({halt, pcW, memW} !== 3'b000) begin
      n_err++; $display("FAIL halt_entry: got %b want 000", {halt, pcW, memW});
    end
    tick();
    idle();
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      n_vec++;
      if ({halt, pcW, ifW, idW, exW, memW} !== 6'b100000) begin
        n_err++; $display("FAIL halted[%0d]: got %b want 100000", i, {halt, pcW, ifW, idW, exW, memW});
      end
      n_vec++;
      if (stall_cnt !== m_stall || flush_cnt !== m_flush) begin
        n_err++; $display("FAIL halt_freeze[%0d]: stall %0d flush %0d want %0d %0d",
                          i, stall_cnt, flush_cnt, m_stall, m_flush);
      end
      tick();
    end
    RST = 1'b1;
    @(negedge CLK);
    n_vec++;
    if (halt !== 1'b0) begin
      n_err++; $display("FAIL halt_rst_comb: halt %b want 0", halt);
    end
    tick();
    idle();
    @(negedge CLK);
    n_vec++;
    if ({halt, pcW, stall_cnt, flush_cnt} !== 10'b0100000000) begin
      n_err++; $display("FAIL halt_cleared: halt %b pcW %b stall %0d flush %0d want 0 1 0 0",
                        halt, pcW, stall_cnt, flush_cnt);
    end
    tick();
  endtask

  task automatic test_ihit_miss();
    idle();
    ihit = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      n_vec++;
      if ({pcW, ifRST, ifW, idW, exW, memW} !== 6'b010111) begin
        n_err++; $display("FAIL ihit_miss[%0d]: got %b want 010111", i, {pcW, ifRST, ifW, idW, exW, memW});
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    idle();
    ihit = 1'b0;
    repeat (20) tick();
    idle();
    @(negedge CLK);
    n_vec++;
    if (stall_cnt !== 4'hF || flush_cnt !== 4'hF) begin
      n_err++; $display("FAIL saturate: stall %0d flush %0d want 15 15", stall_cnt, flush_cnt);
    end
    tick();
  endtask

  task automatic test_random();
    logic [11:0] e;
    for (int i = 0; i < 400; i++) begin
      RST         = ($urandom_range(0, 39) == 0);
      ihit        = ($urandom_range(0, 3) != 0);
      dhit        = $urandom_range(0, 1);
      idrsel1     = 5'($urandom_range(0, 3));
      idrsel2     = 5'($urandom_range(0, 3));
      exwsel      = 5'($urandom_range(0, 3));
      id_uses_rt  = $urandom_range(0, 1);
      idjmp       = ($urandom_range(0, 5) == 0);
      exMemRead   = $urandom_range(0, 1);
      memcuDRE    = ($urandom_range(0, 4) == 0);
      memcuDWE    = ($urandom_range(0, 6) == 0);
      mem_brtaken = ($urandom_range(0, 6) == 0);
      memcuHALT   = ($urandom_range(0, 59) == 0);
      @(negedge CLK);
      e = model_vec();
      n_vec++;
      if ({pcW, pc_sel, ifW, ifRST, idW, idRST, exW, exRST, memW, memRST, halt} !== e) begin
        n_err++; $display("FAIL rand_ctrl[%0d]: got %b want %b", i,
                          {pcW, pc_sel, ifW, ifRST, idW, idRST, exW, exRST, memW, memRST, halt}, e);
      end
      n_vec++;
      if (stall_cnt !== m_stall || flush_cnt !== m_flush) begin
        n_err++; $display("FAIL rand_cnt[%0d]: stall %0d flush %0d want %0d %0d",
                          i, stall_cnt, flush_cnt, m_stall, m_flush);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_stall();
    test_dcache_miss();
    test_branch_flush();
    test_halt();
    test_ihit_miss();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
